// File: rtl/draw_player_if.sv
// VGA stream bundle: timing counters, sync/blank strobes and 12-bit rgb.
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_player.sv
// Player sprite overlay: 2-stage pipeline over a vga_if stream, position/animation latched per frame.
// Optional PLAYER_HITBOX_EN paints the bounding-box outline in magenta.
module draw_player #(
    parameter int unsigned PLAYER_W   = 30,
    parameter int unsigned PLAYER_H   = 80,
    parameter int unsigned EYE_W      = 5,
    parameter int unsigned EYE_Y      = 5,
    parameter int unsigned EYE_H      = 30,
    parameter int unsigned LEG_H      = 20,
    parameter int unsigned ANIM_DIV   = 8,
    parameter logic [11:0] BODY_COLOR = 12'hFFF,
    parameter logic [11:0] EYE_COLOR  = 12'h0FF
) (
    input  logic        clk,
    input  logic        rst_n,
    vga_if.in           vga_in,
    vga_if.out          vga_out,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    input  logic        dir,
    input  logic        moving
);
    localparam int unsigned BODY_W = PLAYER_W - EYE_W;
    localparam int unsigned GAP_W  = 5;
    localparam int unsigned GAP_L  = (BODY_W - GAP_W) / 2;
    localparam int unsigned CNT_W  = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    logic [11:0]      r_xpos_q;
    logic [11:0]      r_ypos_q;
    logic             r_dir_q;
    logic             r_moving_q;
    logic [CNT_W-1:0] r_anim_cnt;
    logic             r_leg_phase;
    logic             r_vblnk_d;
    logic             w_latch;

    // Stage 1 registers
    logic [10:0] r_s1_hcount;
    logic [10:0] r_s1_vcount;
    logic        r_s1_hsync;
    logic        r_s1_vsync;
    logic        r_s1_hblnk;
    logic        r_s1_vblnk;
    logic [11:0] r_s1_rgb;
    logic [11:0] r_s1_rel_x;
    logic [11:0] r_s1_rel_y;
    logic        r_s1_inbox;

    logic [12:0] w_h13;
    logic [12:0] w_v13;
    logic [12:0] w_x13;
    logic [12:0] w_y13;
    logic        w_inbox;

    logic [11:0] w_body_x;
    logic        w_eye_col;
    logic        w_eye_rows;
    logic        w_leg_gap;
    logic [11:0] w_rgb;

    assign w_latch = vga_in.vblnk & ~r_vblnk_d;

    // Frame-synchronous sampling of sprite controls and leg animation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xpos_q    <= 12'd0;
            r_ypos_q    <= 12'd0;
            r_dir_q     <= 1'b1;
            r_moving_q  <= 1'b0;
            r_anim_cnt  <= '0;
            r_leg_phase <= 1'b0;
            r_vblnk_d   <= 1'b0;
        end else begin
            r_vblnk_d <= vga_in.vblnk;
            if (w_latch) begin
                r_xpos_q   <= xpos;
                r_ypos_q   <= ypos;
                r_dir_q    <= dir;
                r_moving_q <= moving;
                if (moving) begin
                    if (r_anim_cnt == CNT_W'(ANIM_DIV - 1)) begin
                        r_anim_cnt  <= '0;
                        r_leg_phase <= ~r_leg_phase;
                    end else begin
                        r_anim_cnt <= r_anim_cnt + CNT_W'(1);
                    end
                end else begin
                    r_anim_cnt  <= '0;
                    r_leg_phase <= 1'b0;
                end
            end
        end
    end

    // 13-bit box bounds so a sprite near 4095 cannot wrap onto column/row 0
    always_comb begin
        w_h13   = 13'(vga_in.hcount);
        w_v13   = 13'(vga_in.vcount);
        w_x13   = 13'(r_xpos_q);
        w_y13   = 13'(r_ypos_q);
        w_inbox = (w_h13 >= w_x13) && (w_h13 < w_x13 + 13'(PLAYER_W)) &&
                  (w_v13 >= w_y13) && (w_v13 < w_y13 + 13'(PLAYER_H));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_hcount <= 11'd0;
            r_s1_vcount <= 11'd0;
            r_s1_hsync  <= 1'b0;
            r_s1_vsync  <= 1'b0;
            r_s1_hblnk  <= 1'b0;
            r_s1_vblnk  <= 1'b0;
            r_s1_rgb    <= 12'd0;
            r_s1_rel_x  <= 12'd0;
            r_s1_rel_y  <= 12'd0;
            r_s1_inbox  <= 1'b0;
        end else begin
            r_s1_hcount <= vga_in.hcount;
            r_s1_vcount <= vga_in.vcount;
            r_s1_hsync  <= vga_in.hsync;
            r_s1_vsync  <= vga_in.vsync;
            r_s1_hblnk  <= vga_in.hblnk;
            r_s1_vblnk  <= vga_in.vblnk;
            r_s1_rgb    <= vga_in.rgb;
            r_s1_rel_x  <= 12'(w_h13 - w_x13);
            r_s1_rel_y  <= 12'(w_v13 - w_y13);
            r_s1_inbox  <= w_inbox;
        end
    end

    // Pixel colour: eye column sits on the facing side, legs open a centre gap in phase 1
    always_comb begin
        w_rgb      = r_s1_rgb;
        w_body_x   = r_dir_q ? r_s1_rel_x : (r_s1_rel_x - 12'(EYE_W));
        w_eye_col  = r_dir_q ? (r_s1_rel_x >= 12'(BODY_W)) : (r_s1_rel_x < 12'(EYE_W));
        w_eye_rows = (r_s1_rel_y >= 12'(EYE_Y)) && (r_s1_rel_y < 12'(EYE_Y + EYE_H));
        w_leg_gap  = r_leg_phase && (r_s1_rel_y >= 12'(PLAYER_H - LEG_H)) &&
                     (w_body_x >= 12'(GAP_L)) && (w_body_x < 12'(GAP_L + GAP_W));
        if (r_s1_inbox && !(r_s1_hblnk || r_s1_vblnk)) begin
            if (w_eye_col) begin
                if (w_eye_rows) begin
                    w_rgb = EYE_COLOR;
                end
            end else if (!w_leg_gap) begin
                w_rgb = BODY_COLOR;
            end
`ifdef PLAYER_HITBOX_EN
            if ((r_s1_rel_x == 12'd0) || (r_s1_rel_x == 12'(PLAYER_W - 1)) ||
                (r_s1_rel_y == 12'd0) || (r_s1_rel_y == 12'(PLAYER_H - 1))) begin
                w_rgb = 12'hF0F;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_out.hcount <= 11'd0;
            vga_out.vcount <= 11'd0;
            vga_out.hsync  <= 1'b0;
            vga_out.vsync  <= 1'b0;
            vga_out.hblnk  <= 1'b0;
            vga_out.vblnk  <= 1'b0;
            vga_out.rgb    <= 12'd0;
        end else begin
            vga_out.hcount <= r_s1_hcount;
            vga_out.vcount <= r_s1_vcount;
            vga_out.hsync  <= r_s1_hsync;
            vga_out.vsync  <= r_s1_vsync;
            vga_out.hblnk  <= r_s1_hblnk;
            vga_out.vblnk  <= r_s1_vblnk;
            vga_out.rgb    <= w_rgb;
        end
    end

endmodule
